// File: rtl/eeprom_image_loader_pkg.sv
// Shared types and widths for the EEPROM-to-RAM boot image loader.
package eeprom_loader_pkg;

    localparam int EE_ADDR_W = 17;
    localparam int LEN_W     = 18;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_REQ_LOW   = 3'd2,
        ST_WAIT_DATA = 3'd3,
        ST_WRITE     = 3'd4,
        ST_NEXT      = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERR       = 3'd7
    } state_t;

    // EEPROM byte addresses wrap at the top of the 128 KiB space.
    function automatic logic [EE_ADDR_W-1:0] next_addr(input logic [EE_ADDR_W-1:0] addr);
        return addr + {{(EE_ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/eeprom_image_loader_if.sv
// Handshake bundle between the loader, the I2C EEPROM reader and the RAM arbiter.
interface eeprom_image_loader_if;
    import eeprom_loader_pkg::*;

    logic                 ee_read_req;
    logic [EE_ADDR_W-1:0] ee_address;
    logic                 ee_ready;
    logic [7:0]           ee_data;
    logic                 mem_we;
    logic [EE_ADDR_W-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic                 mem_ack;

    modport master (
        output ee_read_req, ee_address, mem_we, mem_addr, mem_wdata,
        input  ee_ready, ee_data, mem_ack
    );

    modport slave (
        input  ee_read_req, ee_address, mem_we, mem_addr, mem_wdata,
        output ee_ready, ee_data, mem_ack
    );

endinterface

// File: rtl/eeprom_image_loader_watchdog.sv
// Per-byte watchdog: counts enabled cycles, saturates and flags expiry at all-ones.
module loader_watchdog #(
    parameter int TIMEOUT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count_r;
    logic                 full_s;

    assign full_s  = &count_r;
    assign expired = full_s;

    // Watchdog counter; clear wins over enable, saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {TIMEOUT_W{1'b0}};
        end else if (clear) begin
            count_r <= {TIMEOUT_W{1'b0}};
        end else if (enable && !full_s) begin
            count_r <= count_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/eeprom_image_loader.sv
// Boot sequencer copying a byte image from the EEPROM reader into RAM, one request per byte.
module eeprom_image_loader
    import eeprom_loader_pkg::*;
#(
    parameter int TIMEOUT_W  = 20,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [EE_ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]     length,
    eeprom_image_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_W-1:0]     bytes_loaded
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_s;
    logic                 auto_r;
    logic [EE_ADDR_W-1:0] cursor_r;
    logic [LEN_W-1:0]     remaining_r;
    logic                 ee_read_req_r;
    logic                 mem_we_r;
    logic [EE_ADDR_W-1:0] mem_addr_r;
    logic [7:0]           mem_wdata_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 error_r;
    logic [LEN_W-1:0]     bytes_loaded_r;
    logic                 load_go_s;
    logic                 wd_clear_s;
    logic                 wd_enable_s;
    logic                 wd_expired_s;

    assign bus.ee_read_req = ee_read_req_r;
    assign bus.ee_address  = cursor_r;
    assign bus.mem_we      = mem_we_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign error           = error_r;
    assign bytes_loaded    = bytes_loaded_r;

    loader_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and watchdog control.
    always_comb begin
        state_s     = state_r;
        load_go_s   = 1'b0;
        wd_clear_s  = 1'b0;
        wd_enable_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_go_s = start | auto_r;
                if (load_go_s) begin
                    if (length == LEN_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                wd_clear_s = 1'b1;
                state_s    = ST_REQ_LOW;
            end
            // Counting starts here so expiry lands after 2^TIMEOUT_W-1 waiting cycles.
            ST_REQ_LOW: begin
                wd_enable_s = 1'b1;
                state_s     = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (bus.ee_ready) begin
                    state_s = ST_WRITE;
                end else begin
                    wd_enable_s = 1'b1;
                    if (wd_expired_s) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_WAIT_DATA;
                    end
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_NEXT: begin
                if (remaining_r == LEN_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_r         <= AUTO_START;
            cursor_r       <= {EE_ADDR_W{1'b0}};
            remaining_r    <= LEN_ZERO;
            ee_read_req_r  <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {EE_ADDR_W{1'b0}};
            mem_wdata_r    <= 8'h00;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            bytes_loaded_r <= LEN_ZERO;
        end else begin
            // High only while sitting in REQ, giving the reader a clean rising edge.
            ee_read_req_r <= (state_s == ST_REQ);
            case (state_r)
                ST_IDLE: begin
                    if (load_go_s) begin
                        auto_r         <= 1'b0;
                        cursor_r       <= base_addr;
                        remaining_r    <= length;
                        bytes_loaded_r <= LEN_ZERO;
                        done_r         <= 1'b0;
                        error_r        <= 1'b0;
                        busy_r         <= 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (bus.ee_ready) begin
                        mem_wdata_r <= bus.ee_data;
                        mem_addr_r  <= bytes_loaded_r[EE_ADDR_W-1:0];
                        mem_we_r    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bus.mem_ack) begin
                        mem_we_r       <= 1'b0;
                        bytes_loaded_r <= bytes_loaded_r + LEN_ONE;
                    end
                end
                ST_NEXT: begin
                    cursor_r    <= next_addr(cursor_r);
                    remaining_r <= remaining_r - LEN_ONE;
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
                ST_ERR: begin
                    busy_r  <= 1'b0;
                    error_r <= 1'b1;
                    done_r  <= 1'b0;
                end
                default: begin
                    busy_r <= busy_r;
                end
            endcase
        end
    end

endmodule
